zone_request_gen: RTL
=====================

ZONE_REQUEST_GEN -- requirements
Module: zone_request_gen

Interface
REQ-001 Parameter DEB_CYCLES, default 4, consecutive equal samples required to accept a sensor bit change (>=1).
REQ-002 Parameter WATER_CYCLES, default 16, cycles a granted request is held.
REQ-003 Parameter ACK_TIMEOUT, default 8, maximum cycles to wait for a valve acknowledgement or release.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 S1  in  2  raw dry sensors, group 1 (bit0 sector a, bit1 sector b), 1 = dry.
REQ-007 S2  in  2  raw dry sensors, group 2, same encoding.
REQ-008 R1, R2  in  2 each  valve state returned by the irrigation controller, 1 = open.
REQ-009 E  in  2  controller status; 2'b00 = Error, 2'b01 = no error.
REQ-010 clr  in  1  synchronous fault clear.
REQ-011 G1, G2  out  2 each  zone request codes (00 none, 01 sector a, 10 sector b, 11 both), registered.
REQ-012 busy  out  1  high in any state except IDLE and FAULT.
REQ-013 fault  out  1  high only in FAULT.
REQ-014 cycle_count  out  8  completed irrigation cycles.

Function
REQ-015 Each of the 4 sensor bits SHALL be debounced independently: the debounced value changes only after DEB_CYCLES consecutive identical raw samples differing from it.
REQ-016 FSM states SHALL be IDLE, REQUEST, WATER, RELEASE, FAULT.
REQ-017 IDLE: when any debounced bit is 1, snapshot G1<=deb1 and G2<=deb2 and enter REQUEST on the same edge, so G is valid the next cycle.
REQ-018 REQUEST: if R1==G1 and R2==G2, enter WATER and load the water counter; else if E==2'b00 or ACK_TIMEOUT cycles have elapsed in REQUEST, enter FAULT.
REQ-019 WATER: hold G for exactly WATER_CYCLES cycles, then G<=00 and enter RELEASE; E==2'b00 during WATER enters FAULT.
REQ-020 RELEASE: when R1==00 and R2==00, increment cycle_count and enter IDLE; after ACK_TIMEOUT cycles without this, enter FAULT.
REQ-021 FAULT: G1=G2=00 and fault=1; clr=1 returns to IDLE on the next edge; clr SHALL be ignored in other states.
REQ-022 Sensor changes after the snapshot SHALL NOT alter G1/G2 until the FSM returns to IDLE.
REQ-023 If ack and timeout coincide in REQUEST, ack SHALL win; if ack and E==2'b00 coincide, FAULT SHALL win.
REQ-024 Timer widths SHALL be $clog2(max parameter)+1; no timer SHALL wrap.
REQ-025 cycle_count SHALL saturate at 8'hFF.

Reset
REQ-026 reset low SHALL immediately force IDLE, G1=G2=00, busy=0, fault=0, cycle_count=0, all debounced bits 0 and all counters 0, including mid-operation.

Configuration
REQ-027 With ZONE_REQUEST_GEN_STATS_EN defined, cycle_count SHALL operate per REQ-020/REQ-025.
REQ-028 Without ZONE_REQUEST_GEN_STATS_EN, cycle_count SHALL be constant 8'h00 and no counter register SHALL be built.

Structure
REQ-029 Package zrg_pkg SHALL hold the state enum, request codes (G_NONE, G_A, G_B, G_BOTH) and status codes (E_ERROR=2'b00, E_OK=2'b01).
REQ-030 One sub-module, zrg_debounce (1-bit, DEB_CYCLES parameter), SHALL be instantiated 4 times.

Verification
REQ-031 S1=01 held 4 cycles, R1 echoes G1 two cycles later -> G1=01, G2=00; WATER for 16 cycles; G=00; R=00 -> IDLE, cycle_count=1.
REQ-032 S1=10 pulsed for 3 cycles only -> G stays 00, busy stays 0.
REQ-033 S1=11, S2=01, no valve response -> after 8 cycles in REQUEST, fault=1, G=00; clr=1 -> IDLE next cycle.
REQ-034 E=00 asserted during WATER -> FAULT next cycle, G1=G2=00.
REQ-035 reset low during WATER -> all outputs 0 asynchronously; after release with sensors dry -> new request after 4 cycles.
REQ-036 Run 256 full cycles -> cycle_count=8'hFF with the macro, 8'h00 without it.

Source files
------------

// File: rtl/zrg_pkg.sv
// Shared types for the zone request generator.
// States, request codes and controller status codes.
package zrg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_WATER,
    ST_RELEASE,
    ST_FAULT
  } state_e;

  localparam logic [1:0] G_NONE = 2'b00;
  localparam logic [1:0] G_A    = 2'b01;
  localparam logic [1:0] G_B    = 2'b10;
  localparam logic [1:0] G_BOTH = 2'b11;

  localparam logic [1:0] E_ERROR = 2'b00;
  localparam logic [1:0] E_OK    = 2'b01;

endpackage

// File: rtl/zrg_debounce.sv
// 1-bit debouncer: dout follows din after DEB_CYCLES equal samples.
// Ports: clk, rst_n (async low), din raw, dout debounced.
module zrg_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEB_CYCLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          deb_q, deb_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // A 1-bit input that differs from dout is necessarily a run of
  // identical samples, so counting mismatches is enough.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (din != deb_q) begin
      if (cnt_q == LAST) deb_d = din;
      else               cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      deb_q <= deb_d;
      cnt_q <= cnt_d;
    end
  end

  assign dout = deb_q;

endmodule

// File: rtl/zone_request_gen.sv
// Irrigation zone request FSM: debounced dry sensors -> valve requests.
// Ports: S1/S2 sensors, R1/R2 valve state, E status, clr, G1/G2 requests,
// busy, fault, cycle_count. Macro ZONE_REQUEST_GEN_STATS_EN enables
// the cycle counter; otherwise cycle_count is tied to zero.
module zone_request_gen
  import zrg_pkg::*;
#(
  parameter int DEB_CYCLES   = 4,
  parameter int WATER_CYCLES = 16,
  parameter int ACK_TIMEOUT  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] S1,
  input  logic [1:0] S2,
  input  logic [1:0] R1,
  input  logic [1:0] R2,
  input  logic [1:0] E,
  input  logic       clr,
  output logic [1:0] G1,
  output logic [1:0] G2,
  output logic       busy,
  output logic       fault,
  output logic [7:0] cycle_count
);

  localparam int TMAX =
    (ACK_TIMEOUT > WATER_CYCLES) ? ACK_TIMEOUT : WATER_CYCLES;
  localparam int TW = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TIMEOUT - 1);
  localparam logic [TW-1:0] WAT_LAST = TW'(WATER_CYCLES - 1);

  logic [3:0] raw, deb;

  assign raw = {S2, S1};

  for (genvar i = 0; i < 4; i++) begin : g_deb
    zrg_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .clk  (clk),
      .rst_n(reset),
      .din  (raw[i]),
      .dout (deb[i])
    );
  end

  state_e        state_q, state_d;
  logic [1:0]    g1_q, g1_d;
  logic [1:0]    g2_q, g2_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          ack, err;

  assign ack = (R1 == g1_q) && (R2 == g2_q);
  assign err = (E == E_ERROR);

  // One timer serves all states: counts up in REQUEST/RELEASE,
  // counts down from WATER_CYCLES-1 in WATER.
  always_comb begin
    state_d = state_q;
    g1_d    = g1_q;
    g2_d    = g2_q;
    tmr_d   = tmr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|deb) begin
          g1_d    = deb[1:0];
          g2_d    = deb[3:2];
          tmr_d   = '0;
          state_d = ST_REQUEST;
        end
      end
      ST_REQUEST: begin
        if (err || (!ack && tmr_q == ACK_LAST)) begin
          state_d = ST_FAULT;
        end else if (ack) begin
          tmr_d   = WAT_LAST;
          state_d = ST_WATER;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_WATER: begin
        if (err) begin
          state_d = ST_FAULT;
        end else if (tmr_q == '0) begin
          g1_d    = G_NONE;
          g2_d    = G_NONE;
          state_d = ST_RELEASE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_RELEASE: begin
        if (R1 == G_NONE && R2 == G_NONE) begin
          state_d = ST_IDLE;
        end else if (tmr_q == ACK_LAST) begin
          state_d = ST_FAULT;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_FAULT: begin
        if (clr) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_FAULT) begin
      g1_d  = G_NONE;
      g2_d  = G_NONE;
      tmr_d = '0;
    end
    if (state_d == ST_RELEASE && state_q != ST_RELEASE) tmr_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      g1_q    <= G_NONE;
      g2_q    <= G_NONE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      g1_q    <= g1_d;
      g2_q    <= g2_d;
      tmr_q   <= tmr_d;
    end
  end

  assign G1    = g1_q;
  assign G2    = g2_q;
  assign busy  = (state_q == ST_REQUEST) ||
                 (state_q == ST_WATER)   ||
                 (state_q == ST_RELEASE);
  assign fault = (state_q == ST_FAULT);

`ifdef ZONE_REQUEST_GEN_STATS_EN
  logic       done;
  logic [7:0] cc_q, cc_d;

  assign done = (state_q == ST_RELEASE) &&
                (R1 == G_NONE) && (R2 == G_NONE);

  always_comb begin
    cc_d = cc_q;
    if (done && cc_q != 8'hFF) cc_d = cc_q + 8'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cc_q <= 8'h00;
    else        cc_q <= cc_d;
  end

  assign cycle_count = cc_q;
`else
  assign cycle_count = 8'h00;
`endif

endmodule
